// File: rtl/arith_defs.sv
`default_nettype none
// ============================================================================
//  Module      : arith_defs (package)
//  Description : Shared arithmetic definitions. Provides the add/subtract
//                mode encodings and the segment-width helper used to split
//                a WIDTH-bit operand into STAGES equal ripple segments.
//  Ports       : none (package)
//  Revision    : 1.0 - initial parametrised add/subtract datapath release
// ============================================================================
package arith_defs;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Width of one ripple segment when WIDTH bits are split over STAGES.
    function automatic int seg_w(input int width, input int stages);
        return width / stages;
    endfunction

endpackage

`ifndef SEG_W
`define SEG_W(width, stages) ((width) / (stages))
`endif

`default_nettype wire

// File: rtl/adder_segment.sv
`default_nettype none
// ============================================================================
//  Module      : adder_segment
//  Description : Purely combinational SEG-bit ripple adder built from a chain
//                of full_adder cells. One instance handles one pipeline
//                segment of the wide add/subtract.
//  Ports       : i_a, i_b   - SEG-bit operand slices (b already conditioned)
//                i_cin      - carry into the segment LSB
//                o_sum      - SEG-bit sum slice
//                o_cout     - carry out of the segment MSB
//                o_cmsb     - carry into the segment MSB
//  Revision    : 1.0 - initial release
// ============================================================================
module adder_segment #(
    parameter int SEG = 4
) (
    input  logic [SEG-1:0] i_a,
    input  logic [SEG-1:0] i_b,
    input  logic           i_cin,
    output logic [SEG-1:0] o_sum,
    output logic           o_cout,
    output logic           o_cmsb
);

    // w_c[i] is the carry into bit i; w_c[SEG] leaves the segment.
    logic [SEG:0] w_c;

    assign w_c[0] = i_cin;

    genvar i;
    generate
        for (i = 0; i < SEG; i++) begin : g_bit
            full_adder u_fa (
                .i_a    (i_a[i]),
                .i_b    (i_b[i]),
                .i_cin  (w_c[i]),
                .o_sum  (o_sum[i]),
                .o_cout (w_c[i+1])
            );
        end
    endgenerate

    assign o_cout = w_c[SEG];
    assign o_cmsb = w_c[SEG-1];

endmodule

`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
//  Module      : full_adder
//  Description : Single-bit full adder cell, the building block of every
//                ripple segment.
//  Ports       : i_a, i_b   - operand bits
//                i_cin      - carry in
//                o_sum      - sum bit
//                o_cout     - carry out
//  Revision    : 1.0 - initial release
// ============================================================================
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);

    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

`default_nettype wire

// File: rtl/pipelined_addsub.sv
`default_nettype none
// ============================================================================
//  Module      : pipelined_addsub
//  Description : WIDTH-bit add/subtract split into STAGES ripple segments,
//                one segment per clock, with registered carries between
//                segments, valid/ready flow control (global stall), a
//                subtract mode and a two's-complement overflow flag.
//                Latency is STAGES cycles, throughput one op per cycle.
//  Ports       : clk       - clock, rising edge
//                rst_n     - synchronous active-low reset
//                in_valid  - operands valid
//                in_ready  - operands accepted this cycle
//                a, b      - WIDTH-bit operands
//                cin       - carry in
//                sub       - 0: a+b+cin, 1: a+~b+(cin^1)
//                out_valid - result valid
//                out_ready - downstream accepts result
//                sum       - WIDTH-bit result
//                cout      - raw carry out of the MSB
//                ovf       - signed overflow
//  Revision    : 1.0 - initial release
// ============================================================================
module pipelined_addsub
    import arith_defs::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int c_seg = seg_w(WIDTH, STAGES);

    logic             w_advance;
    logic             w_sub_mode;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_c0;

    // Global stall: the whole pipe moves only when the output slot is free
    // or is being drained this cycle.
    assign w_advance  = !out_valid || out_ready;
    assign in_ready   = w_advance;

    assign w_sub_mode = (sub == MODE_SUB);
    assign w_b_eff    = b ^ {WIDTH{w_sub_mode}};
    assign w_c0       = cin ^ w_sub_mode;

    // Stage k adds segment k. Its register holds:
    //   r_valid/r_carry    - valid bit and carry out of segment k
    //   r_sum              - finished sum slices 0..k (deskew)
    //   g_skew.r_a/r_b     - operand bits not yet added (skew), absent in
    //                        the last stage
    // The last stage doubles as the output register.
    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            localparam int c_rem  = WIDTH - k * c_seg;
            localparam int c_done = (k + 1) * c_seg;
            localparam bit c_last = (k == STAGES - 1);

            logic [c_rem-1:0]  w_a_rem;
            logic [c_rem-1:0]  w_b_rem;
            logic              w_c_in;
            logic              w_v_in;
            logic [c_seg-1:0]  w_seg_sum;
            logic              w_seg_cout;
            logic              w_cmsb_unused;
            logic [c_done-1:0] w_sum_next;

            logic              r_valid;
            logic              r_carry;
            logic [c_done-1:0] r_sum;

            if (k == 0) begin : g_src_in
                assign w_a_rem    = a;
                assign w_b_rem    = w_b_eff;
                assign w_c_in     = w_c0;
                assign w_v_in     = in_valid;
                assign w_sum_next = w_seg_sum;
            end else begin : g_src_prev
                assign w_a_rem    = g_stage[k-1].g_skew.r_a;
                assign w_b_rem    = g_stage[k-1].g_skew.r_b;
                assign w_c_in     = g_stage[k-1].r_carry;
                assign w_v_in     = g_stage[k-1].r_valid;
                assign w_sum_next = {w_seg_sum, g_stage[k-1].r_sum};
            end

            adder_segment #(
                .SEG (c_seg)
            ) u_seg (
                .i_a    (w_a_rem[c_seg-1:0]),
                .i_b    (w_b_rem[c_seg-1:0]),
                .i_cin  (w_c_in),
                .o_sum  (w_seg_sum),
                .o_cout (w_seg_cout),
                .o_cmsb (w_cmsb_unused)
            );

            // Intermediate stages load freely on advance (bubble data is
            // don't-care); the output stage only loads real results so the
            // presented value never changes under a bubble.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_valid <= 1'b0;
                    r_carry <= 1'b0;
                    r_sum   <= '0;
                end else if (w_advance) begin
                    r_valid <= w_v_in;
                    if (!c_last || w_v_in) begin
                        r_carry <= w_seg_cout;
                        r_sum   <= w_sum_next;
                    end
                end
            end

            if (c_last) begin : g_ovf
                logic w_ovf;
                logic r_ovf;

                // The top slice of the last segment carries the operand MSBs.
                assign w_ovf = (w_a_rem[c_seg-1] == w_b_rem[c_seg-1]) &&
                               (w_seg_sum[c_seg-1] != w_a_rem[c_seg-1]);

                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        r_ovf <= 1'b0;
                    end else if (w_advance && w_v_in) begin
                        r_ovf <= w_ovf;
                    end
                end
            end else begin : g_skew
                logic [c_rem-c_seg-1:0] r_a;
                logic [c_rem-c_seg-1:0] r_b;

                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        r_a <= '0;
                        r_b <= '0;
                    end else if (w_advance) begin
                        r_a <= w_a_rem[c_rem-1:c_seg];
                        r_b <= w_b_rem[c_rem-1:c_seg];
                    end
                end
            end
        end
    endgenerate

    assign out_valid = g_stage[STAGES-1].r_valid;
    assign sum       = g_stage[STAGES-1].r_sum;
    assign cout      = g_stage[STAGES-1].r_carry;
    assign ovf       = g_stage[STAGES-1].g_ovf.r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_pipelined_addsub.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipelined_addsub
//  Description : Self-checking bench for pipelined_addsub. A 16/4 instance
//                runs reset, directed carry/subtract and mid-flight reset
//                cases; four further instances (16/4, 8/1, 32/8, 12/3) run
//                directed carry vectors, a backpressure pattern and random
//                streams against an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_addsub;

    int n_checks = 0;
    int n_fail   = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    localparam bit c_pat [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic. Returns {cout, ovf, sum[63:0]}.
    // Subtract is a - b - cin, with cout meaning "no borrow".
    function automatic logic [65:0] ref_addsub(input int w, input longint ua, input longint ub,
                                               input bit ci, input bit sb);
        longint half, full, sa, sbv, ru, rs;
        bit     co, ov;
        half = longint'(1) << (w - 1);
        full = longint'(1) << w;
        sa   = (ua >= half) ? ua - full : ua;
        sbv  = (ub >= half) ? ub - full : ub;
        if (!sb) begin
            ru = ua + ub + longint'(ci);
            rs = sa + sbv + longint'(ci);
            co = (ru >= full);
        end else begin
            ru = ua - ub - longint'(ci);
            rs = sa - sbv - longint'(ci);
            co = (ua >= ub + longint'(ci));
        end
        ru = ((ru % full) + full) % full;
        ov = (rs >= half) || (rs < -half);
        return {co, ov, 64'(ru)};
    endfunction

    // ------------------------------------------------------------------
    // Directed instance (16/4)
    // ------------------------------------------------------------------
    logic        m_rst_n, m_in_valid, m_in_ready, m_cin, m_sub;
    logic        m_out_valid, m_out_ready, m_cout, m_ovf;
    logic [15:0] m_a, m_b, m_sum;

    pipelined_addsub #(.WIDTH(16), .STAGES(4)) u_dut (
        .clk       (clk),
        .rst_n     (m_rst_n),
        .in_valid  (m_in_valid),
        .in_ready  (m_in_ready),
        .a         (m_a),
        .b         (m_b),
        .cin       (m_cin),
        .sub       (m_sub),
        .out_valid (m_out_valid),
        .out_ready (m_out_ready),
        .sum       (m_sum),
        .cout      (m_cout),
        .ovf       (m_ovf)
    );

    task automatic run_one(input logic [15:0] va, input logic [15:0] vb, input logic vc,
                           input logic vs, input logic [15:0] es, input logic ec, input logic eo);
        int lat;
        @(posedge clk); #1;
        m_a = va; m_b = vb; m_cin = vc; m_sub = vs; m_in_valid = 1'b1; m_out_ready = 1'b1;
        @(negedge clk);
        check("dir_in_ready", 64'(m_in_ready), 64'd1);
        @(posedge clk); #1;
        m_in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!m_out_valid && lat < 12);
        check("dir_latency", 64'(lat), 64'd4);
        check("dir_sum", 64'(m_sum), 64'(es));
        check("dir_cout", 64'(m_cout), 64'(ec));
        check("dir_ovf", 64'(m_ovf), 64'(eo));
    endtask

    // ------------------------------------------------------------------
    // Sweep instances: random streams against the reference model
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sweep
            localparam int W = (gi == 0) ? 16 : (gi == 1) ? 8 : (gi == 2) ? 32 : 12;
            localparam int S = (gi == 0) ? 4  : (gi == 1) ? 1 : (gi == 2) ? 8  : 3;

            logic         rst_n, in_valid, in_ready, cin, sub;
            logic         out_valid, out_ready, cout, ovf;
            logic [W-1:0] a, b, sum;
            bit           done = 1'b0;
            logic [65:0]  exp_q [$];
            int           acc_q [$];

            pipelined_addsub #(.WIDTH(W), .STAGES(S)) u_dut (
                .clk       (clk),
                .rst_n     (rst_n),
                .in_valid  (in_valid),
                .in_ready  (in_ready),
                .a         (a),
                .b         (b),
                .cin       (cin),
                .sub       (sub),
                .out_valid (out_valid),
                .out_ready (out_ready),
                .sum       (sum),
                .cout      (cout),
                .ovf       (ovf)
            );

            // mode 0: back-to-back with out_ready pattern, 1: random, 2: directed carry
            task automatic stream(input int nops, input int mode);
                int          nxt, got, cyc, pidx, ac;
                bit          acc, stall, started;
                logic [W-1:0] h_sum;
                logic        h_cout, h_ovf;
                logic [65:0] e;
                longint      va, vb, mask, half;
                string       tg;
                tg    = $sformatf("w%0ds%0dm%0d", W, S, mode);
                mask  = (longint'(1) << W) - 1;
                half  = longint'(1) << (W - 1);
                nxt   = 0; got = 0; cyc = 0; pidx = 0;
                acc   = 1'b0; stall = 1'b0; started = 1'b0;
                h_sum = '0; h_cout = 1'b0; h_ovf = 1'b0;
                in_valid = 1'b0;
                while (got < nops && cyc < nops * 10 + 50) begin
                    @(posedge clk); #1;
                    if (acc) nxt++;
                    if (!in_valid || acc) begin
                        if (nxt < nops && (mode != 1 || $urandom_range(3, 0) != 0)) begin
                            case (mode)
                                2: begin
                                    sub = 1'b0; cin = 1'b0; vb = 1;
                                    case (nxt)
                                        0:       va = (longint'(1) << (W / S)) - 1;
                                        1:       va = mask;
                                        2:       va = half - 1;
                                        3:       begin va = half; sub = 1'b1; end
                                        default: begin va = 5; vb = 7; sub = 1'b1; end
                                    endcase
                                end
                                default: begin
                                    va  = longint'({$urandom, $urandom}) & mask;
                                    vb  = longint'({$urandom, $urandom}) & mask;
                                    cin = 1'($urandom_range(1, 0));
                                    sub = 1'($urandom_range(1, 0));
                                end
                            endcase
                            a = W'(va); b = W'(vb);
                            in_valid = 1'b1;
                        end else begin
                            in_valid = 1'b0;
                        end
                    end
                    case (mode)
                        0: begin
                            out_ready = (started && pidx < 8) ? c_pat[pidx] : 1'b1;
                            if (started) pidx++;
                        end
                        1:       out_ready = ($urandom_range(2, 0) != 0);
                        default: out_ready = 1'b1;
                    endcase
                    @(negedge clk);
                    check({tg, "_in_ready"}, 64'(in_ready), 64'(!out_valid || out_ready));
                    if (stall) begin
                        check({tg, "_hold_valid"}, 64'(out_valid), 64'd1);
                        check({tg, "_hold_sum"}, 64'(sum), 64'(h_sum));
                        check({tg, "_hold_flags"}, {62'd0, cout, ovf}, {62'd0, h_cout, h_ovf});
                    end
                    if (mode == 0 && started && !out_valid)
                        check({tg, "_gap"}, 64'(out_valid), 64'd1);
                    if (out_valid && out_ready) begin
                        if (exp_q.size() == 0) begin
                            check({tg, "_extra"}, 64'(out_valid), 64'd0);
                        end else begin
                            e  = exp_q.pop_front();
                            ac = acc_q.pop_front();
                            check({tg, "_sum"}, 64'(sum), e[63:0]);
                            check({tg, "_cout"}, 64'(cout), 64'(e[65]));
                            check({tg, "_ovf"}, 64'(ovf), 64'(e[64]));
                            if (mode == 2)
                                check({tg, "_latency"}, 64'(cyc - ac), 64'(S));
                            got++;
                        end
                    end
                    if (out_valid) started = 1'b1;
                    acc = in_valid && in_ready;
                    if (acc) begin
                        exp_q.push_back(ref_addsub(W, longint'(a), longint'(b), cin, sub));
                        acc_q.push_back(cyc);
                    end
                    stall  = out_valid && !out_ready;
                    h_sum  = sum; h_cout = cout; h_ovf = ovf;
                    cyc++;
                end
                check({tg, "_count"}, 64'(got), 64'(nops));
                @(posedge clk); #1;
                in_valid  = 1'b0;
                out_ready = 1'b1;
                repeat (S + 2) begin
                    @(negedge clk);
                    check({tg, "_drain"}, 64'(out_valid), 64'd0);
                end
            endtask

            initial begin
                rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
                a = '0; b = '0; cin = 1'b0; sub = 1'b0;
                repeat (2) @(posedge clk);
                #1 rst_n = 1'b1;
                stream(5, 2);
                stream(8, 0);
                stream(1000, 1);
                done = 1'b1;
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Directed sequence and summary
    // ------------------------------------------------------------------
    initial begin
        int t;
        m_rst_n = 1'b0; m_in_valid = 1'b1; m_a = 16'h1234; m_b = 16'h1111;
        m_cin = 1'b0; m_sub = 1'b0; m_out_ready = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            check("rst_out_valid", 64'(m_out_valid), 64'd0);
            check("rst_sum", 64'(m_sum), 64'd0);
            check("rst_cout", 64'(m_cout), 64'd0);
            check("rst_ovf", 64'(m_ovf), 64'd0);
        end
        m_rst_n = 1'b1; m_in_valid = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 64'(m_in_ready), 64'd1);
        check("rst_no_capture", 64'(m_out_valid), 64'd0);

        run_one(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
        run_one(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_one(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_one(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_one(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        // Three operations in flight, then a one-cycle reset discards them.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            m_a = 16'(16'h0100 * (i + 1)); m_b = 16'h0011; m_cin = 1'b0; m_sub = 1'b0;
            m_in_valid = 1'b1;
        end
        @(posedge clk); #1;
        m_in_valid = 1'b0; m_rst_n = 1'b0;
        @(posedge clk); #1;
        m_rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("midrst_out_valid", 64'(m_out_valid), 64'd0);
        end
        run_one(16'h1234, 16'h1111, 1'b1, 1'b0, 16'h2346, 1'b0, 1'b0);

        t = 0;
        while (!(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done && g_sweep[3].done)
               && t < 60000) begin
            @(posedge clk);
            t++;
        end
        check("sweeps_done",
              {60'd0, g_sweep[3].done, g_sweep[2].done, g_sweep[1].done, g_sweep[0].done},
              64'hF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
